// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, mux selects.
// The JR_SUPPORT_EN macro (used by the controller files) enables jr decoding.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_JR     = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] JR_FUNCT = 6'b001000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Opcode-only dispatch out of DECODE; FETCH marks an unsupported opcode.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    logic [3:0] target;
    target = S_FETCH;
    case (op)
      OP_LW, OP_SW: target = S_MEMADR;
      OP_RTYPE:     target = S_EXEC;
      OP_BEQ:       target = S_BRANCH;
      OP_J:         target = S_JUMP;
      OP_ADDI:      target = S_ADDIEX;
      default:      target = S_FETCH;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Next-state logic of the multicycle controller (reset is applied by the caller).
// JR_SUPPORT_EN adds jr decoding and the JR state.
module multicycle_next_state
  import multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_next_state
);

`ifndef JR_SUPPORT_EN
  logic w_unused_funct;
  assign w_unused_funct = ^i_funct;
`endif

  // State transition table; unused codes fall back to FETCH.
  always_comb begin
    o_next_state = S_FETCH;
    case (i_state)
      S_FETCH:  o_next_state = S_DECODE;
      S_DECODE: begin
`ifdef JR_SUPPORT_EN
        if ((i_op == OP_RTYPE) && (i_funct == JR_FUNCT)) begin
          o_next_state = S_JR;
        end else begin
          o_next_state = decode_target(i_op);
        end
`else
        o_next_state = decode_target(i_op);
`endif
      end
      S_MEMADR: begin
        if (i_op == OP_LW) begin
          o_next_state = S_MEMRD;
        end else begin
          o_next_state = S_MEMWR;
        end
      end
      S_MEMRD:  o_next_state = S_MEMWB;
      S_EXEC:   o_next_state = S_RWB;
      S_ADDIEX: o_next_state = S_ADDIWB;
      default:  o_next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register plus Moore output decode (BRANCH pc_write follows zero).
// Define JR_SUPPORT_EN to compile in jr support.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_cur_state;

  multicycle_next_state u_next_state (
    .i_state      (r_state),
    .i_op         (op),
    .i_funct      (funct),
    .o_next_state (w_next_state)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // While reset is held the controller presents FETCH, even before the first edge.
  assign w_cur_state = rst ? S_FETCH : r_state;
  assign state       = w_cur_state;

  // Output decode; anything not driven for a state stays 0.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REG;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (w_cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = ALUB_FOUR;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        illegal   = (w_next_state == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
`ifdef JR_SUPPORT_EN
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_RS;
      end
`endif
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences and packed output vectors per instruction.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;
  logic [15:0] w_outs;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  // {pc_write, pc_src, ir_write, mem_read, mem_write, iord, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal}
  assign w_outs = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and check state and the packed outputs 1 time unit later.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_outs);
    @(posedge clk);
    #1;
    check_val({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
    check_val({tag, "_outs"}, {16'd0, w_outs}, {16'd0, exp_outs});
  endtask

  localparam logic [15:0] O_FETCH  = 16'h9808;
  localparam logic [15:0] O_DECODE = 16'h0018;
  localparam logic [15:0] O_ILL    = 16'h0019;
  localparam logic [15:0] O_MEMADR = 16'h0030;
  localparam logic [15:0] O_MEMRD  = 16'h0A00;
  localparam logic [15:0] O_MEMWB  = 16'h0140;
  localparam logic [15:0] O_MEMWR  = 16'h0600;
  localparam logic [15:0] O_EXEC   = 16'h0024;
  localparam logic [15:0] O_RWB    = 16'h00C0;
  localparam logic [15:0] O_BR_Z0  = 16'h2022;
  localparam logic [15:0] O_BR_Z1  = 16'hA022;
  localparam logic [15:0] O_JUMP   = 16'hC000;
  localparam logic [15:0] O_JR     = 16'hE000;
  localparam logic [15:0] O_ADDIWB = 16'h0040;

  initial begin
    rst   = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;

    // Two reset cycles, then release.
    step("rst1", 4'd0, O_FETCH);
    step("rst2", 4'd0, O_FETCH);
    rst = 1'b0;
    #1;
    check_val("rel_state", {28'd0, state}, 32'd0);
    check_val("rel_outs", {16'd0, w_outs}, {16'd0, O_FETCH});

    op = 6'b100011;
    step("lw_dec", 4'd1, O_DECODE);
    step("lw_adr", 4'd2, O_MEMADR);
    step("lw_rd",  4'd3, O_MEMRD);
    step("lw_wb",  4'd4, O_MEMWB);
    step("lw_end", 4'd0, O_FETCH);

    op = 6'b101011;
    step("sw_dec", 4'd1, O_DECODE);
    step("sw_adr", 4'd2, O_MEMADR);
    step("sw_wr",  4'd5, O_MEMWR);
    step("sw_end", 4'd0, O_FETCH);

    op = 6'b000000; funct = 6'b100000;
    step("r_dec",  4'd1, O_DECODE);
    step("r_exe",  4'd6, O_EXEC);
    step("r_wb",   4'd7, O_RWB);
    step("r_end",  4'd0, O_FETCH);

    funct = 6'b001000;
    step("jr_dec", 4'd1, O_DECODE);
`ifdef JR_SUPPORT_EN
    step("jr_jr",  4'd10, O_JR);
`else
    step("jr_exe", 4'd6, O_EXEC);
    step("jr_wb",  4'd7, O_RWB);
`endif
    step("jr_end", 4'd0, O_FETCH);

    op = 6'b000100; funct = 6'b000000; zero = 1'b0;
    step("beq0_dec", 4'd1, O_DECODE);
    step("beq0_br",  4'd8, O_BR_Z0);
    zero = 1'b1;
    #1;
    check_val("beq_zero_comb", {31'd0, pc_write}, 32'd1);
    zero = 1'b0;
    step("beq0_end", 4'd0, O_FETCH);
    zero = 1'b1;
    step("beq1_dec", 4'd1, O_DECODE);
    step("beq1_br",  4'd8, O_BR_Z1);
    step("beq1_end", 4'd0, O_FETCH);
    zero = 1'b0;

    op = 6'b000010;
    step("j_dec",  4'd1, O_DECODE);
    step("j_jmp",  4'd9, O_JUMP);
    step("j_end",  4'd0, O_FETCH);

    op = 6'b001000;
    step("addi_dec", 4'd1, O_DECODE);
    step("addi_ex",  4'd11, O_MEMADR);
    step("addi_wb",  4'd12, O_ADDIWB);
    step("addi_end", 4'd0, O_FETCH);

    op = 6'b100000; funct = 6'b001000;
    step("ill1_dec", 4'd1, O_ILL);
    step("ill1_end", 4'd0, O_FETCH);
    op = 6'b010100; funct = 6'b011010;
    step("ill2_dec", 4'd1, O_ILL);
    step("ill2_end", 4'd0, O_FETCH);

    // Reset in the middle of a load.
    op = 6'b100011; funct = 6'b000000;
    step("mid_dec", 4'd1, O_DECODE);
    step("mid_adr", 4'd2, O_MEMADR);
    step("mid_rd",  4'd3, O_MEMRD);
    rst = 1'b1;
    step("mid_rst", 4'd0, O_FETCH);
    rst = 1'b0;
    step("post_dec", 4'd1, O_DECODE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
